// File: rtl/fu_issue_ctrl.sv
// Issue scheduler between the reservation station and the functional units.
// A writeback-slot reservation table keeps CDB use per cycle at or below N.
module fu_issue_ctrl #(
  parameter int unsigned N         = 3,
  parameter int unsigned NUM_ALU   = 3,
  parameter int unsigned NUM_MULT  = 2,
  parameter int unsigned NUM_LOAD  = 2,
  parameter int unsigned NUM_STORE = 1,
  parameter int unsigned MULT_LAT  = 4,
  localparam int unsigned CW       = $clog2(N + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic [NUM_ALU-1:0]   fu_alu_issued,
  input  logic [NUM_MULT-1:0]  fu_mult_issued,
  input  logic [NUM_LOAD-1:0]  fu_load_issued,
  input  logic [NUM_STORE-1:0] fu_store_issued,
  input  logic [NUM_LOAD-1:0]  load_wb_req,
  input  logic [NUM_STORE-1:0] store_done,
  output logic [NUM_ALU-1:0]   fu_alu_avail,
  output logic [NUM_MULT-1:0]  fu_mult_avail,
  output logic [NUM_LOAD-1:0]  fu_load_avail,
  output logic [NUM_STORE-1:0] fu_store_avail,
  output logic [NUM_LOAD-1:0]  load_wb_gnt,
  output logic [CW-1:0]        cdb_free_cnt
);

  localparam logic [CW:0] NFull = (CW + 1)'(N);
  localparam logic [CW:0] One   = (CW + 1)'(1);

  // res_q[k] holds CDB slots already claimed for the cycle k ahead of now.
  logic [CW-1:0]        res_q [MULT_LAT];
  logic [CW-1:0]        res_d [MULT_LAT];
  logic [NUM_LOAD-1:0]  load_busy_q, load_busy_d;
  logic [NUM_STORE-1:0] store_busy_q, store_busy_d;

  logic [NUM_ALU-1:0]  alu_av;
  logic [NUM_MULT-1:0] mult_av;
  logic [NUM_LOAD-1:0] gnt;
  logic [CW:0]         alu_acc, mult_acc, load_acc, alu_cnt, mult_cnt;

  always_comb begin
    mult_av  = '0;
    alu_av   = '0;
    gnt      = '0;
    mult_acc = '0;
    mult_cnt = '0;
    alu_cnt  = '0;
    alu_acc  = {1'b0, res_q[1]};
    load_acc = {1'b0, res_q[0]};

    // Multipliers are served first: their slot lies furthest ahead.
    for (int unsigned j = 0; j < NUM_MULT; j++) begin
      mult_av[j] = mult_acc < NFull;
      if (mult_av[j]) mult_acc = mult_acc + One;
      if (mult_av[j] && fu_mult_issued[j]) mult_cnt = mult_cnt + One;
    end

    for (int unsigned j = 0; j < NUM_ALU; j++) begin
      alu_av[j] = alu_acc < NFull;
      if (alu_av[j]) alu_acc = alu_acc + One;
      if (alu_av[j] && fu_alu_issued[j]) alu_cnt = alu_cnt + One;
    end

    // Loads take whatever is left of the current cycle's slots.
    for (int unsigned j = 0; j < NUM_LOAD; j++) begin
      gnt[j] = load_wb_req[j] && load_busy_q[j] && (load_acc < NFull);
      if (gnt[j]) load_acc = load_acc + One;
    end
  end

  assign fu_alu_avail   = alu_av;
  assign fu_mult_avail  = mult_av;
  assign fu_load_avail  = ~load_busy_q;
  assign fu_store_avail = ~store_busy_q;
  assign load_wb_gnt    = gnt;
  assign cdb_free_cnt   = CW'(NFull - load_acc);

  always_comb begin
    for (int unsigned k = 0; k < MULT_LAT - 1; k++) begin
      res_d[k] = res_q[k + 1];
    end
    res_d[MULT_LAT-1] = CW'(mult_cnt);
    res_d[0]          = CW'({1'b0, res_d[0]} + alu_cnt);

    load_busy_d  = (load_busy_q & ~gnt) | (fu_load_issued & ~load_busy_q);
    store_busy_d = (store_busy_q & ~store_done) | (fu_store_issued & ~store_busy_q);
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int unsigned k = 0; k < MULT_LAT; k++) begin
        res_q[k] <= '0;
      end
      load_busy_q  <= '0;
      store_busy_q <= '0;
    end else begin
      for (int unsigned k = 0; k < MULT_LAT; k++) begin
        res_q[k] <= res_d[k];
      end
      load_busy_q  <= load_busy_d;
      store_busy_q <= store_busy_d;
    end
  end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Scoreboard bench for fu_issue_ctrl: a per-absolute-cycle CDB booking model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_fu_issue_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned NA = 3;
  localparam int unsigned NM = 2;
  localparam int unsigned NL = 2;
  localparam int unsigned NS = 1;
  localparam int unsigned ML = 4;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int          HS = 64;

  logic          clock, reset, squash;
  logic [NA-1:0] fu_alu_issued, fu_alu_avail;
  logic [NM-1:0] fu_mult_issued, fu_mult_avail;
  logic [NL-1:0] fu_load_issued, fu_load_avail, load_wb_req, load_wb_gnt;
  logic [NS-1:0] fu_store_issued, fu_store_avail, store_done;
  logic [CW-1:0] cdb_free_cnt;

  fu_issue_ctrl #(
    .N(N), .NUM_ALU(NA), .NUM_MULT(NM), .NUM_LOAD(NL), .NUM_STORE(NS), .MULT_LAT(ML)
  ) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_alu_issued(fu_alu_issued), .fu_mult_issued(fu_mult_issued),
    .fu_load_issued(fu_load_issued), .fu_store_issued(fu_store_issued),
    .load_wb_req(load_wb_req), .store_done(store_done),
    .fu_alu_avail(fu_alu_avail), .fu_mult_avail(fu_mult_avail),
    .fu_load_avail(fu_load_avail), .fu_store_avail(fu_store_avail),
    .load_wb_gnt(load_wb_gnt), .cdb_free_cnt(cdb_free_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NA-1:0] alu;
    logic [NM-1:0] mult;
    logic [NL-1:0] ld_av;
    logic [NS-1:0] st_av;
    logic [NL-1:0] gnt;
    int            free;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  // Model: CDB results booked per absolute cycle number, plus unit busy flags.
  int  booked [HS];
  bit  lbusy [NL];
  bit  sbusy [NS];
  int  t = 0;
  bit  model_valid = 0;

  task automatic clear_model();
    for (int i = 0; i < HS; i++) booked[i] = 0;
    for (int j = 0; j < NL; j++) lbusy[j] = 0;
    for (int j = 0; j < NS; j++) sbusy[j] = 0;
  endtask

  task automatic step(input logic [NA-1:0] a, input logic [NM-1:0] m,
                      input logic [NL-1:0] l, input logic [NS-1:0] s,
                      input logic [NL-1:0] rq, input logic [NS-1:0] d,
                      input bit sq, input bit rs);
    exp_t e;
    int room0, room1, g, na, nm;
    @(posedge clock);
    #1;
    fu_alu_issued = a; fu_mult_issued = m; fu_load_issued = l; fu_store_issued = s;
    load_wb_req = rq; store_done = d; squash = sq; reset = rs;

    if (model_valid) begin
      room1 = N - booked[(t + 1) % HS];
      room0 = N - booked[t % HS];
      e.alu = '0; e.mult = '0; e.gnt = '0;
      for (int j = 0; j < NA; j++) if (j < room1) e.alu[j] = 1'b1;
      for (int j = 0; j < NM; j++) if (j < N) e.mult[j] = 1'b1;
      for (int j = 0; j < NL; j++) e.ld_av[j] = !lbusy[j];
      for (int j = 0; j < NS; j++) e.st_av[j] = !sbusy[j];
      g = 0;
      for (int j = 0; j < NL; j++) begin
        if (rq[j] && lbusy[j] && g < room0) begin
          e.gnt[j] = 1'b1;
          g++;
        end
      end
      e.free = room0 - g;
      q.push_back(e);
      pushed++;

      if (!(rs || sq)) begin
        na = 0; nm = 0;
        for (int j = 0; j < NA; j++) if (a[j] && e.alu[j]) na++;
        for (int j = 0; j < NM; j++) if (m[j] && e.mult[j]) nm++;
        booked[(t + 1) % HS] += na;
        booked[(t + ML) % HS] += nm;
        for (int j = 0; j < NL; j++) begin
          if (e.gnt[j]) lbusy[j] = 0;
          if (l[j] && e.ld_av[j]) lbusy[j] = 1;
        end
        for (int j = 0; j < NS; j++) begin
          if (d[j]) sbusy[j] = 0;
          if (s[j] && e.st_av[j]) sbusy[j] = 1;
        end
      end
    end
    if (rs || sq) begin
      clear_model();
      if (rs) model_valid = 1;
    end
    booked[t % HS] = 0;
    t++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      popped++;
      chk("alu_avail", int'(fu_alu_avail), int'(e.alu));
      chk("mult_avail", int'(fu_mult_avail), int'(e.mult));
      chk("load_avail", int'(fu_load_avail), int'(e.ld_av));
      chk("store_avail", int'(fu_store_avail), int'(e.st_av));
      chk("load_wb_gnt", int'(load_wb_gnt), int'(e.gnt));
      chk("cdb_free_cnt", int'(cdb_free_cnt), e.free);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0;
    fu_alu_issued = '0; fu_mult_issued = '0; fu_load_issued = '0; fu_store_issued = '0;
    load_wb_req = '0; store_done = '0;
    clear_model();

    step('0, '0, '0, '0, '0, '0, 0, 1);
    step('0, '0, '0, '0, '0, '0, 0, 1);
    step('0, '0, '0, '0, '0, '0, 0, 0);
    // Both multipliers, then watch the reservation walk toward the CDB.
    step('0, 2'b11, '0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step('0, '0, '0, '0, '0, '0, 0, 0);
    // Busy both loads, fill the next cycle with ALUs, then request writeback.
    step('0, '0, 2'b11, '0, '0, '0, 0, 0);
    step(3'b111, '0, '0, '0, '0, '0, 0, 0);
    step('0, '0, 2'b11, '0, 2'b11, '0, 0, 0);
    step('0, '0, '0, '0, 2'b11, '0, 0, 0);
    step('0, '0, '0, '0, '0, '0, 0, 0);
    // Store held busy until done, then a spurious done.
    step('0, '0, '0, 1'b1, '0, '0, 0, 0);
    step('0, '0, '0, 1'b1, '0, '0, 0, 0);
    step('0, '0, '0, '0, '0, '0, 0, 0);
    step('0, '0, '0, '0, '0, 1'b1, 0, 0);
    step('0, '0, '0, '0, '0, 1'b1, 0, 0);
    step('0, '0, '0, '0, '0, '0, 0, 0);
    // Multipliers then squash with a load issue that must be dropped.
    step('0, 2'b11, '0, '0, '0, '0, 0, 0);
    step(3'b111, '0, 2'b10, '0, '0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step('0, '0, '0, '0, '0, '0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(NA'($urandom()),
           ($urandom_range(0, 2) == 0) ? NM'($urandom()) : '0,
           NL'($urandom()), NS'($urandom()), NL'($urandom()),
           ($urandom_range(0, 3) == 0) ? NS'($urandom()) : '0,
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) == 0));
    end

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    chk("pop_count", popped, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_issue_ctrl.md
Name: fu_issue_ctrl

Overview:
- Issue scheduler between the reservation station and the functional units.
- Each cycle it produces the per-FU `avail` vectors the RS uses for selection.
- A writeback-slot reservation table ensures no cycle ever has more than `N` results on the CDB.
- It tracks busy state of variable-latency load and store units and grants loads their CDB slots.

Parameters:
- N, `N, CDB width (results broadcast per cycle).
- NUM_ALU, `NUM_FU_ALU, single-cycle ALUs (result on CDB 1 cycle after issue).
- NUM_MULT, `NUM_FU_MULT, pipelined multipliers (result on CDB MULT_LAT cycles after issue); MULT_LAT >= 2 required.
- NUM_LOAD, `NUM_FU_LOAD, variable-latency load units, one op in flight each.
- NUM_STORE, `NUM_FU_STORE, store units, one op in flight each, no CDB use.
- MULT_LAT, 4, multiplier issue-to-CDB latency in cycles.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  pipeline flush; same effect as reset on next edge
- fu_alu_issued  in  NUM_ALU  RS issued to ALU j this cycle
- fu_mult_issued  in  NUM_MULT  RS issued to MULT j this cycle
- fu_load_issued  in  NUM_LOAD  RS issued to LOAD j this cycle
- fu_store_issued  in  NUM_STORE  RS issued to STORE j this cycle
- load_wb_req  in  NUM_LOAD  load j has data, requests CDB slot this cycle
- store_done  in  NUM_STORE  store j completed
- fu_alu_avail  out  NUM_ALU  ALU j may be issued this cycle
- fu_mult_avail  out  NUM_MULT  MULT j may be issued this cycle
- fu_load_avail  out  NUM_LOAD  LOAD j idle
- fu_store_avail  out  NUM_STORE  STORE j idle
- load_wb_gnt  out  NUM_LOAD  load j drives CDB this cycle
- cdb_free_cnt  out  $clog2(N+1)  CDB slots unused in the current cycle after load grants

Behaviour:
- State:
  - `res[0..MULT_LAT-1]`, each $clog2(N+1) bits; `res[k]` = CDB slots already reserved for cycle t+k. `res[MULT_LAT]` is implicitly 0.
  - `load_busy[NUM_LOAD]` and `store_busy[NUM_STORE]` flags.
- All outputs are combinational from state and same-cycle inputs; a new issue updates state at the next posedge.
- Mult avail: greedy, lowest index first. MULT j is avail iff (number of lower-index MULTs avail) < N.
- ALU avail: greedy, lowest index first. ALU j is avail iff res[1] + (mult issues targeting t+1, always 0 since MULT_LAT >= 2) + (lower-index ALUs avail) < N.
- Multipliers take priority because their slot lies furthest ahead.
- Load grant: lowest index first. Load j is granted iff load_wb_req[j] & load_busy[j] & (res[0] + lower-index grants) < N.
  - An ungranted load keeps requesting; stall is the requester's job.
- cdb_free_cnt = N - res[0] - popcount(load_wb_gnt).
- fu_load_avail[j] = ~load_busy[j]; fu_store_avail[j] = ~store_busy[j].
- Gating: effective issue = issued & avail; issued bits without avail are ignored (no state change).
- Next state on posedge:
  - res'[k] = res[k+1] for k < MULT_LAT-1; res'[MULT_LAT-1] = 0.
  - Then add popcount(effective ALU issues) to res'[0] and popcount(effective MULT issues) to res'[MULT_LAT-1].
  - Sums never exceed N by construction. Loads consume res[0] only in the current cycle and create no reservation.
- Busy flags:
  - load_busy[j] set on effective load issue, cleared when load_wb_gnt[j].
  - If a grant and a new issue hit the same load in the same cycle, the issue is impossible (avail = 0 while busy).
  - store_busy[j] set on effective store issue, cleared on store_done[j].
  - store_done while not busy is ignored.
- Reset or squash: res = 0, all busy flags = 0.
  - On the following cycle, outputs are: first min(NUM_MULT,N) mult avail, first min(NUM_ALU,N) ALU avail, all load/store avail, load_wb_gnt = 0, cdb_free_cnt = N.
  - Squash takes precedence over same-cycle issues, grants, and done signals.

Test Plan (N=3, NUM_ALU=3, NUM_MULT=2, NUM_LOAD=2, NUM_STORE=1, MULT_LAT=4):
1. Reset, no issues -> alu_avail=3'b111, mult_avail=2'b11, load_avail=2'b11, store_avail=1, cdb_free_cnt=3, load_wb_gnt=0.
2. Issue both MULTs at cycle 0 -> cycles 1-2: alu_avail=111. Cycle 3: alu_avail=3'b001 (res[1]=2). Cycle 4: cdb_free_cnt=1 before loads.
3. Issue 3 ALUs at cycle 0 and assert both load_wb_req (loads busy) at cycle 1 -> cycle 1: load_wb_gnt=00, cdb_free_cnt=0. Cycle 2: load_wb_gnt=11, cdb_free_cnt=1.
4. Issue LOAD0 -> next cycle load_avail=10. load_wb_req[0] granted -> following cycle load_avail=11. Asserting fu_load_issued[0] while busy -> no change.
5. Issue STORE0, then store_done 3 cycles later -> store_avail 0 for exactly 3 cycles, then 1. Spurious store_done while idle -> no effect.
6. Both MULTs issued, then squash next cycle with LOAD1 issued -> all reservations cleared, load_avail=11, cdb_free_cnt=3 on every later cycle.
